// File: rtl/slab_interval_reduce.sv
// slab_interval_reduce: folds per-axis (tnear, tfar) slab pairs into one
// ray/box interval, tmin = max(tnear) and tmax = min(tfar), then reports a
// registered hit/miss. Values use the FloPoCo encoding
// {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
module slab_interval_reduce #(
    parameter int WE       = 11,
    parameter int WF       = 7,
    parameter int WIDTH    = WE + WF + 2,
    parameter int NUM_AXES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_tnear,
    input  logic [WIDTH:0]   in_tfar,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [WIDTH:0]   out_tmin,
    output logic [WIDTH:0]   out_tmax
);

    typedef enum logic [1:0] {ACC, EVAL, RESULT} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ax;
    logic [WIDTH:0]   tmin, tmax;
    logic             nan_seen;
    logic             accept, last;

    function automatic logic is_nan(input logic [WIDTH:0] x);
        return x[WIDTH:WIDTH-1] == 2'b11;
    endfunction

    // Coarse ordering class: -inf < -normal < zero < +normal < +inf.
    function automatic logic [2:0] rank(input logic [WIDTH:0] x);
        logic [2:0] r;
        case (x[WIDTH:WIDTH-1])
            2'b00:   r = 3'd2;
            2'b01:   r = x[WIDTH-2] ? 3'd1 : 3'd3;
            default: r = x[WIDTH-2] ? 3'd0 : 3'd4;
        endcase
        return r;
    endfunction

    // Strict a > b; NaN on either side never compares greater. Two normals
    // of the same sign fall through to a magnitude compare, reversed when
    // negative. Zeros of either sign share a class and so compare equal.
    function automatic logic gt(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic res;
        res = 1'b0;
        if (is_nan(a) || is_nan(b))
            res = 1'b0;
        else if (rank(a) != rank(b))
            res = rank(a) > rank(b);
        else if (a[WIDTH:WIDTH-1] == 2'b01)
            res = a[WIDTH-2] ? (a[WIDTH-3:0] < b[WIDTH-3:0])
                             : (a[WIDTH-3:0] > b[WIDTH-3:0]);
        return res;
    endfunction

    assign in_ready  = (state == ACC);
    assign out_valid = (state == RESULT);
    assign accept    = in_valid && in_ready;
    assign last      = (ax == 2'(NUM_AXES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // Next-state: accumulate axes, one evaluate cycle, hold result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && last) state_nxt = EVAL;
            EVAL:    state_nxt = RESULT;
            RESULT:  if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // Running interval; the first axis of a ray overwrites, later axes narrow.
    // Ties keep the held value since only a strict compare replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax       <= '0;
            tmin     <= '0;
            tmax     <= '0;
            nan_seen <= 1'b0;
        end else if (accept) begin
            ax <= last ? 2'd0 : ax + 2'd1;
            if (ax == 2'd0) begin
                tmin     <= in_tnear;
                tmax     <= in_tfar;
                nan_seen <= is_nan(in_tnear) | is_nan(in_tfar);
            end else begin
                if (gt(in_tnear, tmin)) tmin <= in_tnear;
                if (gt(tmax, in_tfar))  tmax <= in_tfar;
                nan_seen <= nan_seen | is_nan(in_tnear) | is_nan(in_tfar);
            end
        end
    end

    // Result registers, loaded once per ray in EVAL and held through RESULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_hit  <= 1'b0;
            out_tmin <= '0;
            out_tmax <= '0;
        end else if (state == EVAL) begin
            out_hit  <= !nan_seen && !gt(tmin, tmax) && !gt('0, tmax);
            out_tmin <= tmin;
            out_tmax <= tmax;
        end
    end

endmodule

// File: tb/tb_slab_interval_reduce.sv
// Directed bench for slab_interval_reduce: hand-computed rays covering hit,
// miss, behind-origin, NaN, signed-zero tie, input gaps, backpressure and
// mid-ray reset.
module tb_slab_interval_reduce;

    localparam int W = 20;
    localparam logic [W:0] P1   = 21'h09FF80;  // +1.0
    localparam logic [W:0] P2   = 21'h0A0000;  // +2.0
    localparam logic [W:0] Z    = 21'h000000;  // +0
    localparam logic [W:0] NZ   = 21'h040000;  // -0
    localparam logic [W:0] N1   = 21'h0DFF80;  // -1.0
    localparam logic [W:0] QNAN = 21'h180000;  // exception 11

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_hit;
    logic [W:0]   in_tnear, in_tfar, out_tmin, out_tmax;
    int           nerr = 0;
    int           nchk = 0;

    slab_interval_reduce dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tnear  (in_tnear),
        .in_tfar   (in_tfar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_tmin  (out_tmin),
        .out_tmax  (out_tmax)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pair for exactly one edge (in_ready is high in ACC).
    task automatic send(input logic [W:0] n, input logic [W:0] f);
        in_valid = 1'b1;
        in_tnear = n;
        in_tfar  = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Last pair already sent: check EVAL cycle, result cycle, then take it.
    task automatic finish_ray(input string name, input logic eh,
                              input logic [W:0] emin, input logic [W:0] emax);
        chk({name, "_eval_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_eval_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_hit"},   32'(out_hit),   32'(eh));
        chk({name, "_tmin"},  32'(out_tmin),  32'(emin));
        chk({name, "_tmax"},  32'(out_tmax),  32'(emax));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_back_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_tnear = '0; in_tfar = '0;
        #12;
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_hit",   32'(out_hit),   32'd0);
        chk("rst_tmin",  32'(out_tmin),  32'd0);
        chk("rst_tmax",  32'(out_tmax),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Hit: tmin = max(0,1,0) = 1, tmax = min(2,2,1) = 1.
        send(Z, P2); send(P1, P2); send(Z, P1);
        finish_ray("hit", 1'b1, P1, P1);

        // Disjoint, with idle gaps mid-ray: tmin 2 > tmax 1.
        send(P2, P2);
        repeat (3) @(posedge clk);
        #0;
        send(Z, P1);
        @(posedge clk); #1;
        send(Z, P2);
        finish_ray("miss", 1'b0, P2, P1);

        // Box entirely behind the origin: tmax = -1 < 0.
        send(N1, N1); send(N1, N1); send(N1, N1);
        finish_ray("behind", 1'b0, N1, N1);

        // NaN in axis 1 tfar forces a miss; NaN never wins the min.
        send(Z, P2); send(Z, QNAN); send(Z, P2);
        finish_ray("nan", 1'b0, Z, P2);

        // Following ray must not inherit the NaN flag.
        send(Z, P2); send(P1, P2); send(Z, P1);
        finish_ray("after_nan", 1'b1, P1, P1);

        // -0 ties +0: earlier +0 is kept as tmin.
        send(Z, P2); send(NZ, P2); send(NZ, P2);
        finish_ray("zero_tie", 1'b1, Z, P2);

        // Backpressure: result held 5 cycles, offered input ignored.
        send(Z, P2); send(P1, P2); send(Z, P1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_tnear = N1; in_tfar = N1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready),  32'd0);
            chk("bp_hit",   32'(out_hit),   32'd1);
            chk("bp_tmin",  32'(out_tmin),  32'(P1));
            chk("bp_tmax",  32'(out_tmax),  32'(P1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", 32'(out_valid), 32'd0);

        // Reset after two pairs: outputs clear at once, partial ray lost.
        send(N1, N1); send(N1, N1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_hit",   32'(out_hit),   32'd0);
        chk("mid_rst_tmin",  32'(out_tmin),  32'd0);
        chk("mid_rst_tmax",  32'(out_tmax),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Fresh ray after reset starts at axis 0.
        send(Z, P2); send(P1, P2); send(Z, P1);
        finish_ray("post_rst", 1'b1, P1, P1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
